// File: rtl/rgb888_ycbcr444_pkg.sv
// Shared constants, pipeline stage types and arithmetic helpers for the RGB888 -> YCbCr444 converter.
// PIPE_LAT is also the sync alignment depth used by the LUT stages further downstream.
package rgb888_ycbcr444_pkg;

   localparam logic [7:0] Y_R  = 8'd77;
   localparam logic [7:0] Y_G  = 8'd150;
   localparam logic [7:0] Y_B  = 8'd29;
   localparam logic [7:0] CB_R = 8'd43;
   localparam logic [7:0] CB_G = 8'd85;
   localparam logic [7:0] CB_B = 8'd128;
   localparam logic [7:0] CR_R = 8'd128;
   localparam logic [7:0] CR_G = 8'd107;
   localparam logic [7:0] CR_B = 8'd21;

   localparam logic signed [17:0] CHROMA_OFFSET = 18'sd32768;
   localparam int unsigned        PIPE_LAT      = 32'd3;

   typedef struct packed {
      logic [15:0] y_r;
      logic [15:0] y_g;
      logic [15:0] y_b;
      logic [15:0] cb_r;
      logic [15:0] cb_g;
      logic [15:0] cb_b;
      logic [15:0] cr_r;
      logic [15:0] cr_g;
      logic [15:0] cr_b;
      logic        de;
   } prod_t;

   typedef struct packed {
      logic [16:0] y;
      logic [16:0] cb;
      logic [16:0] cr;
      logic        de;
   } sum_t;

   function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] k);
      return {8'h00, a} * {8'h00, k};
   endfunction

   function automatic logic [7:0] sat8(input logic [16:0] s);
      return s[16] ? 8'hFF : s[15:8];
   endfunction

endpackage

// File: rtl/rgb888_ycbcr444_sync_delay_line.sv
// Fixed-depth 1-bit shift register used to align frame/line/enable syncs with the data pipeline.
module sync_delay_line #(
   parameter int unsigned DEPTH = 32'd3
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [DEPTH-1:0] dly_q;
   logic [DEPTH-1:0] dly_d;

   always_comb begin
      dly_d = {dly_q[DEPTH-2:0], d_i};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dly_q <= '0;
      end else begin
         dly_q <= dly_d;
      end
   end

   assign q_o = dly_q[DEPTH-1];

endmodule

// File: rtl/rgb888_ycbcr444.sv
// Three-stage BT.601 full-range RGB888 -> YCbCr444 converter with sync signals delayed to match.
// The data pipeline carries its own copy of clken so the blanking gate lands on the stage-3 register.
module rgb888_ycbcr444 #(
   parameter bit BLANK_ZERO = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       per_frame_vsync,
   input  logic       per_frame_href,
   input  logic       per_frame_clken,
   input  logic [7:0] per_img_red,
   input  logic [7:0] per_img_green,
   input  logic [7:0] per_img_blue,
   output logic       post_frame_vsync,
   output logic       post_frame_href,
   output logic       post_frame_clken,
   output logic [7:0] post_img_Y,
   output logic [7:0] post_img_Cb,
   output logic [7:0] post_img_Cr
);
   import rgb888_ycbcr444_pkg::*;

   prod_t             s1_d, s1_q;
   sum_t              s2_d, s2_q;
   logic [7:0]        y_d, cb_d, cr_d;
   logic [7:0]        y_q, cb_q, cr_q;
   logic signed [17:0] cb_full_s, cr_full_s;

   always_comb begin
      s1_d.y_r  = mul8(per_img_red,   Y_R);
      s1_d.y_g  = mul8(per_img_green, Y_G);
      s1_d.y_b  = mul8(per_img_blue,  Y_B);
      s1_d.cb_r = mul8(per_img_red,   CB_R);
      s1_d.cb_g = mul8(per_img_green, CB_G);
      s1_d.cb_b = mul8(per_img_blue,  CB_B);
      s1_d.cr_r = mul8(per_img_red,   CR_R);
      s1_d.cr_g = mul8(per_img_green, CR_G);
      s1_d.cr_b = mul8(per_img_blue,  CR_B);
      s1_d.de   = per_frame_clken;
   end

   // Chroma cannot go negative with these coefficients; the floor at 0 only guards the bit-17 sign.
   always_comb begin
      cb_full_s = $signed({2'b00, s1_q.cb_b}) + CHROMA_OFFSET
                - $signed({2'b00, s1_q.cb_r}) - $signed({2'b00, s1_q.cb_g});
      cr_full_s = $signed({2'b00, s1_q.cr_r}) + CHROMA_OFFSET
                - $signed({2'b00, s1_q.cr_g}) - $signed({2'b00, s1_q.cr_b});
      s2_d.y  = {1'b0, s1_q.y_r} + {1'b0, s1_q.y_g} + {1'b0, s1_q.y_b};
      s2_d.cb = cb_full_s[17] ? 17'd0 : cb_full_s[16:0];
      s2_d.cr = cr_full_s[17] ? 17'd0 : cr_full_s[16:0];
      s2_d.de = s1_q.de;
   end

   always_comb begin
      if (BLANK_ZERO && !s2_q.de) begin
         y_d  = 8'd0;
         cb_d = 8'd0;
         cr_d = 8'd0;
      end else begin
         y_d  = sat8(s2_q.y);
         cb_d = sat8(s2_q.cb);
         cr_d = sat8(s2_q.cr);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
         y_q  <= 8'd0;
         cb_q <= 8'd0;
         cr_q <= 8'd0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         y_q  <= y_d;
         cb_q <= cb_d;
         cr_q <= cr_d;
      end
   end

   assign post_img_Y  = y_q;
   assign post_img_Cb = cb_q;
   assign post_img_Cr = cr_q;

   sync_delay_line #(.DEPTH(PIPE_LAT)) u_vsync_dly (
      .clk (clk),
      .rst (rst),
      .d_i (per_frame_vsync),
      .q_o (post_frame_vsync)
   );

   sync_delay_line #(.DEPTH(PIPE_LAT)) u_href_dly (
      .clk (clk),
      .rst (rst),
      .d_i (per_frame_href),
      .q_o (post_frame_href)
   );

   sync_delay_line #(.DEPTH(PIPE_LAT)) u_clken_dly (
      .clk (clk),
      .rst (rst),
      .d_i (per_frame_clken),
      .q_o (post_frame_clken)
   );

endmodule

// File: tb/tb_rgb888_ycbcr444.sv
// Scoreboard bench: the driver pushes the reference-model result for every cycle's input,
// a negedge monitor pops and compares once the entry is PIPE_LAT cycles old.
module tb_rgb888_ycbcr444;

   typedef struct packed {
      logic [7:0] y;
      logic [7:0] cb;
      logic [7:0] cr;
      logic [7:0] ry;
      logic [7:0] rcb;
      logic [7:0] rcr;
      logic       vs;
      logic       hs;
      logic       ce;
      logic       live;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       vs_in, hs_in, ce_in;
   logic [7:0] r_in, g_in, b_in;
   logic       vs_o, hs_o, ce_o;
   logic [7:0] y_o, cb_o, cr_o;
   logic       nb_vs_o, nb_hs_o, nb_ce_o;
   logic [7:0] nb_y_o, nb_cb_o, nb_cr_o;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   rgb888_ycbcr444 #(.BLANK_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst),
      .per_frame_vsync(vs_in), .per_frame_href(hs_in), .per_frame_clken(ce_in),
      .per_img_red(r_in), .per_img_green(g_in), .per_img_blue(b_in),
      .post_frame_vsync(vs_o), .post_frame_href(hs_o), .post_frame_clken(ce_o),
      .post_img_Y(y_o), .post_img_Cb(cb_o), .post_img_Cr(cr_o)
   );

   rgb888_ycbcr444 #(.BLANK_ZERO(1'b0)) dut_nb (
      .clk(clk), .rst(rst),
      .per_frame_vsync(vs_in), .per_frame_href(hs_in), .per_frame_clken(ce_in),
      .per_img_red(r_in), .per_img_green(g_in), .per_img_blue(b_in),
      .post_frame_vsync(nb_vs_o), .post_frame_href(nb_hs_o), .post_frame_clken(nb_ce_o),
      .post_img_Y(nb_y_o), .post_img_Cb(nb_cb_o), .post_img_Cr(nb_cr_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int clamp255(input int v);
      return (v > 255) ? 255 : ((v < 0) ? 0 : v);
   endfunction

   // BT.601 full range, integer coefficients, truncating divide by 256
   function automatic exp_t model(input int r, input int g, input int b,
                                  input logic vs, input logic hs, input logic ce);
      exp_t e;
      int   y, cb, cr;
      y  = clamp255((77 * r + 150 * g + 29 * b) / 256);
      cb = clamp255((128 * b + 32768 - 43 * r - 85 * g) / 256);
      cr = clamp255((128 * r + 32768 - 107 * g - 21 * b) / 256);
      e.ry   = 8'(y);
      e.rcb  = 8'(cb);
      e.rcr  = 8'(cr);
      e.y    = ce ? 8'(y)  : 8'd0;
      e.cb   = ce ? 8'(cb) : 8'd0;
      e.cr   = ce ? 8'(cr) : 8'd0;
      e.vs   = vs;
      e.hs   = hs;
      e.ce   = ce;
      e.live = 1'b1;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
      end
   endtask

   // A reset edge flushes every pixel in flight; the pixel presented on that edge is lost too.
   task automatic step(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic vs, input logic hs, input logic ce, input logic rs);
      exp_t z;
      z = '0;
      r_in = r; g_in = g; b_in = b;
      vs_in = vs; hs_in = hs; ce_in = ce;
      rst = rs;
      @(posedge clk);
      if (rs) begin
         foreach (sb_q[i]) sb_q[i] = z;
         sb_q.push_back(z);
      end else begin
         sb_q.push_back(model(int'(r), int'(g), int'(b), vs, hs, ce));
      end
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() >= 3) begin
         e = sb_q.pop_front();
         chk("Y",     y_o,  e.y);
         chk("Cb",    cb_o, e.cb);
         chk("Cr",    cr_o, e.cr);
         chk("vsync", {7'd0, vs_o}, {7'd0, e.vs});
         chk("href",  {7'd0, hs_o}, {7'd0, e.hs});
         chk("clken", {7'd0, ce_o}, {7'd0, e.ce});
         chk("nb_clken", {7'd0, nb_ce_o}, {7'd0, e.ce});
         chk("nb_vsync", {7'd0, nb_vs_o}, {7'd0, e.vs});
         chk("nb_href",  {7'd0, nb_hs_o}, {7'd0, e.hs});
         if (e.live) begin
            chk("nb_Y",  nb_y_o,  e.ry);
            chk("nb_Cb", nb_cb_o, e.rcb);
            chk("nb_Cr", nb_cr_o, e.rcr);
         end
      end
   end

   initial begin
      exp_t z;
      logic vs_r;
      z = '0;
      rst = 1'b1;
      r_in = 8'd0; g_in = 8'd0; b_in = 8'd0;
      vs_in = 1'b0; hs_in = 1'b0; ce_in = 1'b0;
      // two empty slots so the first edges under reset are checked as all-zero outputs
      sb_q.push_back(z);
      sb_q.push_back(z);

      repeat (3) step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

      step(8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b1, 1'b0);
      step(8'd255, 8'd255, 8'd255, 1'b0, 1'b1, 1'b1, 1'b0);
      step(8'd255, 8'd0,   8'd0,   1'b0, 1'b1, 1'b1, 1'b0);
      step(8'd0,   8'd255, 8'd0,   1'b0, 1'b1, 1'b1, 1'b0);
      step(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
      step(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
      step(8'd0,   8'd0,   8'd255, 1'b0, 1'b1, 1'b1, 1'b0);

      // distinct pixels back-to-back with a 5-wide vsync pulse, two frames
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 12; i++) begin
            step(8'(i * 21 + f), 8'(255 - i * 17), 8'(i * 9 + 40),
                 (i >= 1 && i <= 5) ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0);
         end
      end

      // single-cycle reset mid-line with the pipeline full
      step(8'd200, 8'd10, 8'd90, 1'b0, 1'b1, 1'b1, 1'b0);
      step(8'd201, 8'd11, 8'd91, 1'b0, 1'b1, 1'b1, 1'b0);
      step(8'd202, 8'd12, 8'd92, 1'b0, 1'b1, 1'b1, 1'b1);
      step(8'd77,  8'd88, 8'd99, 1'b0, 1'b1, 1'b1, 1'b0);
      step(8'd10,  8'd20, 8'd30, 1'b0, 1'b1, 1'b1, 1'b0);

      // random video with occasional vsync pulses, blanking and rare resets
      vs_r = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 19) == 0) vs_r = ~vs_r;
         step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              vs_r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
      end

      repeat (4) step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
